// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared definitions for the divided-clock frequency monitor:
//   - mon_state_t : monitor FSM state encoding
//   - MIN_SYNC_STAGES / MAX_CNT_W : legal parameter limits
//   - tol_lo()    : lower tolerance bound, clamped at zero
//   - params_ok() : elaboration-time sanity check of a parameter set
// -----------------------------------------------------------------------------
package clk_mon_pkg;

   typedef enum logic [1:0] {
      ST_UNARMED = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } mon_state_t;

   localparam int MIN_SYNC_STAGES = 2;
   localparam int MAX_CNT_W       = 31;

   // Lower edge of the tolerance window; never goes below zero.
   function automatic int tol_lo(input int exp_period, input int tol);
      int lo;
      if (exp_period > tol) begin
         lo = exp_period - tol;
      end else begin
         lo = 0;
      end
      return lo;
   endfunction

   // True when the parameter set can be built as intended.
   function automatic bit params_ok(input int cnt_w, input int sync_stages,
                                    input int timeout, input int lock_count,
                                    input int tol);
      bit     ok;
      longint cnt_max;
      ok = 1'b1;
      if ((cnt_w < 1) || (cnt_w > MAX_CNT_W)) begin
         ok      = 1'b0;
         cnt_max = 64'sd0;
      end else begin
         cnt_max = (64'sd1 <<< cnt_w) - 64'sd1;
      end
      if (sync_stages < MIN_SYNC_STAGES) begin
         ok = 1'b0;
      end
      // TIMEOUT has to be reachable strictly below the saturation value
      if ((timeout < 1) || (longint'(timeout) >= cnt_max)) begin
         ok = 1'b0;
      end
      if ((lock_count < 1) || (tol < 0)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage : clk_mon_pkg

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the i_clk domain through a SYNC_STAGES
// flop chain and flags its transitions against a previous-value register.
//
// Ports:
//   i_clk    in  system clock
//   i_reset  in  synchronous active-high reset (chain and history clear to 0)
//   i_async  in  asynchronous input level
//   o_rise   out high for one cycle after the synchronized level goes 0->1
//   o_fall   out high for one cycle after the synchronized level goes 1->0
//   o_level  out synchronized level
// The outputs are decoded from flops only, so they are glitch-free; the parent
// registers them together with its own status outputs.
// -----------------------------------------------------------------------------
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall,
   output logic o_level
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   // Synchronizer shift chain plus one-cycle history of the synchronized level
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= w_sync;
      end
   end

   assign o_rise  = w_sync & ~r_prev;
   assign o_fall  = ~w_sync & r_prev;
   assign o_level = w_sync;

endmodule : sync_edge_detect

// File: rtl/clk_freq_monitor.sv
// -----------------------------------------------------------------------------
// clk_freq_monitor
// Watches the divided clock coming from the upstream divider and turns it into
// clean i_clk-domain rise/fall strobes, a measured period (in i_clk cycles)
// and health status (locked / lost).
//
// Ports:
//   i_clk           in  system clock (single clock domain)
//   i_reset         in  synchronous active-high reset
//   i_mon_clk       in  monitored divided clock, asynchronous
//   o_rise_tick     out one-cycle strobe per detected rising edge
//   o_fall_tick     out one-cycle strobe per detected falling edge
//   o_period        out last published period, held between updates
//   o_period_valid  out one-cycle strobe when o_period updates
//   o_locked        out level, high while locked to EXP_PERIOD +/- TOL
//   o_lost          out level, high after TIMEOUT cycles without a rise
// All outputs are registered; a tick, its period and the status change it
// causes all appear on the same cycle.
// -----------------------------------------------------------------------------
module clk_freq_monitor
   import clk_mon_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int EXP_PERIOD  = 100,
   parameter int TOL         = 2,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = 1000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_mon_clk,
   output logic             o_rise_tick,
   output logic             o_fall_tick,
   output logic [CNT_W-1:0] o_period,
   output logic             o_period_valid,
   output logic             o_locked,
   output logic             o_lost
);

   if (!params_ok(CNT_W, SYNC_STAGES, TIMEOUT, LOCK_COUNT, TOL)) begin : g_param_check
      $error("clk_freq_monitor: illegal parameter set");
   end

   localparam int                GOOD_W    = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]    TOL_LO_C  = (CNT_W+1)'(tol_lo(EXP_PERIOD, TOL));
   localparam logic [CNT_W:0]    TOL_HI_C  = (CNT_W+1)'(EXP_PERIOD + TOL);
   localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);
   localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

   // edge detection
   logic w_rise;
   logic w_fall;
   logic w_unused_level;

   // interval counter and period
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W:0]   w_period_ext;
   logic             w_in_tol;
   logic             w_timeout;

   // FSM
   mon_state_t        r_state;
   mon_state_t        w_state_nxt;
   logic [GOOD_W-1:0] r_good_cnt;
   logic [GOOD_W-1:0] w_good_inc;
   logic [GOOD_W-1:0] w_good_nxt;
   logic              w_publish;

   // registered outputs
   logic             r_rise_tick;
   logic             r_fall_tick;
   logic [CNT_W-1:0] r_period;
   logic             r_period_valid;
   logic             r_locked;
   logic             r_lost;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_async (i_mon_clk),
      .o_rise  (w_rise),
      .o_fall  (w_fall),
      .o_level (w_unused_level)
   );

   // cnt + 1 saturating doubles as the measured period of the interval
   // that a rise in this cycle closes.
   assign w_cnt_inc    = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
   assign w_cnt_nxt    = w_rise ? {CNT_W{1'b0}} : w_cnt_inc;
   assign w_period_ext = {1'b0, w_cnt_inc};
   assign w_in_tol     = (w_period_ext >= TOL_LO_C) && (w_period_ext <= TOL_HI_C);
   // Looking at the next count makes o_lost rise exactly TIMEOUT cycles after
   // the last tick; a simultaneous rise takes priority.
   assign w_timeout    = ~w_rise && (w_cnt_inc == TIMEOUT_C);
   assign w_good_inc   = r_good_cnt + GOOD_ONE;

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_UNARMED;
         r_good_cnt <= {GOOD_W{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_nxt;
      end
   end

   // FSM next state, good-period run length and publish decision
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_publish   = 1'b0;
      case (r_state)
         ST_UNARMED: begin
            // first edge only arms; the interval before it is not a period
            if (w_rise) begin
               w_state_nxt = ST_MEASURE;
               w_good_nxt  = {GOOD_W{1'b0}};
            end else if (w_timeout) begin
               w_state_nxt = ST_LOST;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_MEASURE: begin
            if (w_rise) begin
               w_publish = 1'b1;
               if (w_in_tol) begin
                  if (w_good_inc == LOCK_C) begin
                     w_state_nxt = ST_LOCKED;
                  end else begin
                     w_state_nxt = ST_MEASURE;
                  end
                  w_good_nxt = w_good_inc;
               end else begin
                  w_good_nxt = {GOOD_W{1'b0}};
               end
            end else if (w_timeout) begin
               w_state_nxt = ST_LOST;
               w_good_nxt  = {GOOD_W{1'b0}};
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_LOCKED: begin
            if (w_rise) begin
               w_publish = 1'b1;
               if (w_in_tol) begin
                  w_state_nxt = ST_LOCKED;
               end else begin
                  w_state_nxt = ST_MEASURE;
                  w_good_nxt  = {GOOD_W{1'b0}};
               end
            end else if (w_timeout) begin
               w_state_nxt = ST_LOST;
               w_good_nxt  = {GOOD_W{1'b0}};
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_LOST: begin
            // re-arm edge: the gap it closes is not published
            if (w_rise) begin
               w_state_nxt = ST_MEASURE;
               w_good_nxt  = {GOOD_W{1'b0}};
            end else begin
               w_state_nxt = r_state;
            end
         end
         default: begin
            w_state_nxt = ST_UNARMED;
            w_good_nxt  = {GOOD_W{1'b0}};
         end
      endcase
   end

   // Interval counter and registered outputs; status follows the next state
   // so it changes on the same cycle as the tick that causes it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt          <= {CNT_W{1'b0}};
         r_rise_tick    <= 1'b0;
         r_fall_tick    <= 1'b0;
         r_period       <= {CNT_W{1'b0}};
         r_period_valid <= 1'b0;
         r_locked       <= 1'b0;
         r_lost         <= 1'b0;
      end else begin
         r_cnt          <= w_cnt_nxt;
         r_rise_tick    <= w_rise;
         r_fall_tick    <= w_fall;
         r_period_valid <= w_publish;
         if (w_publish) begin
            r_period <= w_cnt_inc;
         end
         r_locked       <= (w_state_nxt == ST_LOCKED);
         r_lost         <= (w_state_nxt == ST_LOST);
      end
   end

   assign o_rise_tick    = r_rise_tick;
   assign o_fall_tick    = r_fall_tick;
   assign o_period       = r_period;
   assign o_period_valid = r_period_valid;
   assign o_locked       = r_locked;
   assign o_lost         = r_lost;

endmodule : clk_freq_monitor
